ram_lookup_reader: RTL and testbench

- Read-side client for the simple dual-port lookup RAMs used in the match/action stages.
- Accepts lookup requests (address + tag) over a valid/ready handshake and drives the RAM read port.
- Absorbs the RAM's one-cycle read latency and returns data + tag over a valid/ready response stream, with full backpressure.
- Snoops the RAM write port so that a write and a read to the same address on the same edge return the new data.

---
 rtl/ram_lookup_reader.sv | 113 +++++++++++
 tb/tb_ram_lookup_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lookup_reader.sv
`default_nettype none
// ram_lookup_reader: lookup-RAM read client. It absorbs the one-cycle RAM read latency and
// forwards a write that lands on the read's issue edge. Results return through a 3-entry FIFO.
module ram_lookup_reader #(
   parameter int ADDR_BITS = 5,
   parameter int DATA_BITS = 193,
   parameter int TAG_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [TAG_BITS-1:0]  req_tag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_BITS-1:0] rsp_data,
   output logic [TAG_BITS-1:0]  rsp_tag,
   output logic [ADDR_BITS-1:0] ram_addrb,
   output logic                 ram_enb,
   input  logic [DATA_BITS-1:0] ram_doutb,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data
);

   localparam int         ENTRY_BITS = DATA_BITS + TAG_BITS;
   localparam logic [1:0] PTR_LAST   = 2'd2;
   localparam logic [1:0] OCC_MAX    = 2'd3;

   logic                  acc;
   logic                  pop;
   logic                  push;
   logic [ENTRY_BITS-1:0] push_entry;

   logic                  infl_valid_q, infl_valid_d;
   logic                  fwd_q, fwd_d;
   logic [TAG_BITS-1:0]   infl_tag_q;
   logic [DATA_BITS-1:0]  fwd_data_q;
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [ENTRY_BITS-1:0] mem_q [3];

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
   endfunction

   // Occupancy counts the in-flight read too, so a push can never meet a full FIFO.
   always_comb begin
      req_ready  = aresetn & (occ_q != OCC_MAX);
      acc        = req_valid & req_ready;
      rsp_valid  = (cnt_q != 2'd0);
      pop        = rsp_valid & rsp_ready;
      push       = infl_valid_q;
      push_entry = {(fwd_q ? fwd_data_q : ram_doutb), infl_tag_q};
   end

   always_comb begin
      infl_valid_d = acc;
      fwd_d        = acc & wr_en & (wr_addr == req_addr);
      wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d        = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      occ_d = occ_q;
      case ({acc, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      ram_addrb           = req_addr;
      ram_enb             = acc;
      {rsp_data, rsp_tag} = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         infl_valid_q <= 1'b0;
         fwd_q        <= 1'b0;
         occ_q        <= 2'd0;
         cnt_q        <= 2'd0;
         wr_ptr_q     <= 2'd0;
         rd_ptr_q     <= 2'd0;
      end else begin
         infl_valid_q <= infl_valid_d;
         fwd_q        <= fwd_d;
         occ_q        <= occ_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; its contents only matter behind a valid flag.
   always_ff @(posedge clk) begin
      infl_tag_q <= req_tag;
      fwd_data_q <= wr_data;
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_lookup_reader.sv
`default_nettype none
// Bench for ram_lookup_reader: behavioural RAM plus a queue model of outstanding responses
// that predicts ready/valid timing and returned data/tag on every cycle.
module tb_ram_lookup_reader;
   localparam int AB  = 5;
   localparam int DB  = 193;
   localparam int TGB = 8;

   logic           clk, aresetn, req_valid, req_ready, rsp_valid, rsp_ready, ram_enb, wr_en;
   logic [AB-1:0]  req_addr, ram_addrb, wr_addr;
   logic [TGB-1:0] req_tag, rsp_tag;
   logic [DB-1:0]  rsp_data, ram_doutb, wr_data;
   logic [DB-1:0]  mem [32];

   typedef struct {
      logic [DB-1:0]  d;
      logic [TGB-1:0] t;
      int             vis;
   } exp_t;

   exp_t           q[$];
   logic [DB-1:0]  obs_d[$];
   logic [TGB-1:0] obs_t[$];
   int             cyc = 0;
   int             n_cmp = 0;
   int             n_bad = 0;
   logic           e_ready, e_valid, m_acc;

   ram_lookup_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TGB)) dut (
      .clk(clk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_doutb(ram_doutb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first RAM: a same-edge read returns the old word.
   always @(posedge clk) begin
      if (ram_enb) ram_doutb <= mem[ram_addrb];
      if (wr_en)   mem[wr_addr] <= wr_data;
   end

   function automatic logic [DB-1:0] rnd_data();
      logic [DB-1:0] r;
      r = '0;
      for (int k = 0; k < 7; k++) r = {r[DB-33:0], $urandom};
      return r;
   endfunction

   // Predict this cycle's outputs from the outstanding-response queue.
   task automatic pre();
      #1;
      e_ready = aresetn && (q.size() < 3);
      e_valid = 1'b0;
      if (q.size() > 0) e_valid = (q[0].vis <= cyc);
   endtask

   // Apply this cycle's accept/pop to the model, then advance one clock.
   task automatic post();
      exp_t e;
      m_acc = req_valid && e_ready;
      if (e_valid && rsp_ready) begin
         obs_d.push_back(rsp_data);
         obs_t.push_back(rsp_tag);
         void'(q.pop_front());
      end
      if (m_acc) begin
         e.d   = (wr_en && wr_addr == req_addr) ? wr_data : mem[req_addr];
         e.t   = req_tag;
         e.vis = cyc + 2;
         q.push_back(e);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
      req_valid = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
      pre(); post();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; req_valid = 1'b1; req_addr = 5'd3; req_tag = 8'h01; rsp_ready = 1'b1; wr_en = 1'b0;
      #1;
      n_cmp += 3;
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset.req_ready got=%b exp=0", req_ready); end
      if (ram_enb   !== 1'b0) begin n_bad++; $display("FAIL reset.ram_enb got=%b exp=0", ram_enb); end
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset.rsp_valid got=%b exp=0", rsp_valid); end
      req_valid = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      n_cmp += 2;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset.release_ready got=%b exp=1", req_ready); end
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset.release_valid got=%b exp=0", rsp_valid); end
      @(negedge clk);
      for (int a = 0; a < 32; a++) preload(5'(a), rnd_data());
   endtask

   task automatic test_single();
      int nv = 0, first = -1;
      obs_d.delete(); obs_t.delete();
      preload(5'd3, DB'(32'h1ABC));
      for (int i = 0; i < 6; i++) begin
         req_valid = (i == 0); req_addr = 5'd3; req_tag = 8'h55; rsp_ready = 1'b1;
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL single.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL single.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL single.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         if (rsp_valid === 1'b1) begin nv++; if (first < 0) first = i; end
         post();
      end
      n_cmp += 2;
      if (nv != 1 || first != 2) begin n_bad++; $display("FAIL single.timing valid_cycles=%0d first=%0d exp 1/2", nv, first); end
      if (obs_d.size() != 1) begin n_bad++; $display("FAIL single.count got=%0d exp=1", obs_d.size()); end
      else if (obs_d[0] !== DB'(32'h1ABC) || obs_t[0] !== 8'h55) begin
         n_bad++; $display("FAIL single.value got=%h/%h exp=1abc/55", obs_d[0], obs_t[0]);
      end
   endtask

   task automatic test_stream();
      int drops = 0, first = -1, last = -1, bad_order = 0;
      obs_d.delete(); obs_t.delete();
      for (int i = 0; i < 20; i++) begin
         req_valid = (i < 16); req_addr = 5'(i); req_tag = 8'(i); rsp_ready = 1'b1;
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL stream.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL stream.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL stream.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         if (i < 16 && req_ready !== 1'b1) drops++;
         if (rsp_valid === 1'b1) begin if (first < 0) first = i; last = i; end
         post();
      end
      for (int k = 0; k < obs_t.size(); k++) if (obs_t[k] !== 8'(k)) bad_order++;
      n_cmp += 3;
      if (drops != 0) begin n_bad++; $display("FAIL stream.ready_drops got=%0d exp=0", drops); end
      if (obs_t.size() != 16 || bad_order != 0) begin n_bad++; $display("FAIL stream.order count=%0d misordered=%0d exp 16/0", obs_t.size(), bad_order); end
      if (first != 2 || last != 17) begin n_bad++; $display("FAIL stream.span first=%0d last=%0d exp 2/17", first, last); end
   endtask

   task automatic test_backpressure();
      int acc_n = 0;
      obs_d.delete(); obs_t.delete();
      for (int i = 0; i < 12; i++) begin
         req_valid = (i < 6); req_addr = 5'($urandom_range(0, 31)); req_tag = 8'(i); rsp_ready = (i >= 6);
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL bp.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL bp.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL bp.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         if (req_valid && req_ready === 1'b1) acc_n++;
         if (i == 6 || i == 7) begin
            n_cmp++;
            if (req_ready !== (i == 7)) begin n_bad++; $display("FAIL bp.ready_return i=%0d got=%b exp=%b", i, req_ready, (i == 7)); end
         end
         post();
      end
      n_cmp += 2;
      if (acc_n != 3) begin n_bad++; $display("FAIL bp.accepted got=%0d exp=3", acc_n); end
      if (obs_t.size() != 3) begin n_bad++; $display("FAIL bp.drain count=%0d exp=3", obs_t.size()); end
      else if (obs_t[0] !== 8'd0 || obs_t[1] !== 8'd1 || obs_t[2] !== 8'd2) begin
         n_bad++; $display("FAIL bp.drain tags=%0d,%0d,%0d exp=0,1,2", obs_t[0], obs_t[1], obs_t[2]);
      end
   endtask

   task automatic test_forward();
      obs_d.delete(); obs_t.delete();
      preload(5'd7, DB'(32'hAAAA));
      for (int i = 0; i < 10; i++) begin
         req_valid = (i < 2); req_addr = 5'd7; req_tag = (i == 0) ? 8'hA0 : 8'hB0;
         wr_en = (i == 1 || i == 2); wr_addr = 5'd7; wr_data = (i == 1) ? DB'(32'hBBBB) : DB'(32'hCCCC);
         rsp_ready = (i >= 4);
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL fwd.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL fwd.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL fwd.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         post();
      end
      wr_en = 1'b0;
      n_cmp++;
      if (obs_d.size() != 2) begin n_bad++; $display("FAIL fwd.count got=%0d exp=2", obs_d.size()); end
      else if (obs_d[0] !== DB'(32'hAAAA) || obs_d[1] !== DB'(32'hBBBB)) begin
         n_bad++; $display("FAIL fwd.value got=%h,%h exp=aaaa,bbbb", obs_d[0], obs_d[1]);
      end
   endtask

   task automatic test_reset_mid();
      int nv = 0;
      obs_d.delete(); obs_t.delete();
      preload(5'd1, DB'(32'h1111_0001));
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = 5'($urandom_range(0, 31)); req_tag = 8'(8'hE0 + i); rsp_ready = 1'b0;
         pre(); post();
      end
      req_valid = 1'b0;
      #1 aresetn = 1'b0;
      #1;
      n_cmp += 2;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid.rsp_valid got=%b exp=0", rsp_valid); end
      if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid.req_ready got=%b exp=0", req_ready); end
      q.delete();
      #2 aresetn = 1'b1;
      @(posedge clk); cyc++; @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         req_valid = (i == 1); req_addr = 5'd1; req_tag = 8'h77; rsp_ready = 1'b1;
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL rstmid.after_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL rstmid.after_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (rsp_valid === 1'b1) nv++;
         post();
      end
      n_cmp++;
      if (nv != 1 || obs_d.size() != 1) begin n_bad++; $display("FAIL rstmid.count valid_cycles=%0d pops=%0d exp 1/1", nv, obs_d.size()); end
      else if (obs_d[0] !== DB'(32'h1111_0001) || obs_t[0] !== 8'h77) begin
         n_bad++; $display("FAIL rstmid.value got=%h/%h exp=11110001/77", obs_d[0], obs_t[0]);
      end
   endtask

   task automatic test_wrap();
      int sent = 0, outst = 0, bad_order = 0;
      obs_d.delete(); obs_t.delete();
      for (int k = 0; k < 80 && obs_t.size() < 10; k++) begin
         req_valid = (sent < 10); req_addr = 5'($urandom_range(0, 31)); req_tag = 8'(8'h40 + sent);
         rsp_ready = (k % 2 == 0);
         pre();
         n_cmp += 2;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL wrap.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL wrap.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL wrap.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         if (req_valid && req_ready === 1'b1) outst++;
         if (rsp_valid === 1'b1 && rsp_ready) outst--;
         n_cmp++;
         if (outst > 3) begin n_bad++; $display("FAIL wrap.occupancy got=%0d exp<=3", outst); end
         post();
         if (m_acc) sent++;
      end
      for (int k = 0; k < obs_t.size(); k++) if (obs_t[k] !== 8'(8'h40 + k)) bad_order++;
      n_cmp++;
      if (obs_t.size() != 10 || bad_order != 0) begin n_bad++; $display("FAIL wrap.order count=%0d misordered=%0d exp 10/0", obs_t.size(), bad_order); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 306; i++) begin
         req_valid = (i < 300) && ($urandom_range(0, 9) < 7);
         req_addr  = 5'($urandom_range(0, 3)); req_tag = 8'($urandom);
         wr_en     = (i < 300) && ($urandom_range(0, 9) < 4);
         wr_addr   = 5'($urandom_range(0, 3)); wr_data = rnd_data();
         rsp_ready = (i >= 300) || ($urandom_range(0, 1) == 1);
         pre();
         n_cmp += 3;
         if (req_ready !== e_ready) begin n_bad++; $display("FAIL rand.req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
         if (rsp_valid !== e_valid) begin n_bad++; $display("FAIL rand.rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); end
         if (ram_enb !== (req_valid && e_ready) || (ram_enb === 1'b1 && ram_addrb !== req_addr)) begin
            n_bad++; $display("FAIL rand.ram_port cyc=%0d got=%b/%0d exp=%b/%0d", cyc, ram_enb, ram_addrb, (req_valid && e_ready), req_addr);
         end
         if (e_valid) begin
            n_cmp++;
            if (rsp_data !== q[0].d || rsp_tag !== q[0].t) begin n_bad++; $display("FAIL rand.rsp cyc=%0d got=%h/%h exp=%h/%h", cyc, rsp_data, rsp_tag, q[0].d, q[0].t); end
         end
         post();
      end
      wr_en = 1'b0; req_valid = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; rsp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_forward();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
